// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared encodings and I2C engine field widths for the bus arbiter slice.
package i2c_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_OWNED   = 3'd1,
        ARB_ABORT   = 3'd2,
        ARB_RELEASE = 3'd3
    } arb_state_e;

    localparam int unsigned WDATA_W = 32;
    localparam int unsigned NM_W    = 5;
    localparam int unsigned ERRT_W  = 8;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned WD_W    = 20;

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after rr_ptr_i.
module rr_pick
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        int unsigned cand;
        logic        found;
        cand     = 0;
        found    = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr_i) + k) % N_REQ;
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = IDX_W'(cand);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin lock arbiter sharing one I2C_Bus engine between N_REQ controllers,
// with error-count and hold-watchdog aborts.
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int unsigned       N_REQ     = 2,
    parameter logic [ERRT_W-1:0] ERR_LIMIT = 8'd3,
    parameter logic [WD_W-1:0]   HOLD_MAX  = 20'd400000
) (
    input  logic                     clk_in,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_en,
    input  logic [N_REQ-1:0]         req_wr,
    input  logic [WDATA_W*N_REQ-1:0] req_wdata,
    input  logic [WDATA_W*N_REQ-1:0] req_rdata,
    input  logic [NM_W*N_REQ-1:0]    req_nm,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         abort,
    output logic                     bus_en,
    output logic                     bus_wr,
    output logic [WDATA_W-1:0]       bus_wdata,
    output logic [WDATA_W-1:0]       bus_rdata,
    output logic [NM_W-1:0]          bus_nm,
    input  logic                     bus_done,
    input  logic [ERRT_W-1:0]        bus_error_time,
    output logic                     busy
);

    arb_state_e          state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    abort_q, abort_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                bus_en_q, bus_en_d;
    logic                bus_wr_q, bus_wr_d;
    logic [WDATA_W-1:0]  bus_wdata_q, bus_wdata_d;
    logic [WDATA_W-1:0]  bus_rdata_q, bus_rdata_d;
    logic [NM_W-1:0]     bus_nm_q, bus_nm_d;

    logic [N_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;

    logic                sel_req, sel_en, sel_wr;
    logic [WDATA_W-1:0]  sel_wdata, sel_rdata;
    logic [NM_W-1:0]     sel_nm;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    // One-hot grant mux avoids indexing the narrow vectors with a 2-bit owner index.
    always_comb begin
        sel_en    = 1'b0;
        sel_wr    = 1'b0;
        sel_wdata = '0;
        sel_rdata = '0;
        sel_nm    = '0;
        sel_req   = |(req & gnt_q);
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                sel_en    = req_en[i];
                sel_wr    = req_wr[i];
                sel_wdata = req_wdata[i*WDATA_W +: WDATA_W];
                sel_rdata = req_rdata[i*WDATA_W +: WDATA_W];
                sel_nm    = req_nm[i*NM_W +: NM_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        abort_d     = abort_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        wd_d        = wd_q;
        bus_en_d    = 1'b0;
        bus_wr_d    = bus_wr_q;
        bus_wdata_d = bus_wdata_q;
        bus_rdata_d = bus_rdata_q;
        bus_nm_d    = bus_nm_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_OWNED;
                    gnt_d   = pick_onehot;
                    owner_d = pick_idx;
                    wd_d    = '0;
                end
            end
            ARB_OWNED: begin
                bus_en_d    = sel_en;
                bus_wr_d    = sel_wr;
                bus_wdata_d = sel_wdata;
                bus_rdata_d = sel_rdata;
                bus_nm_d    = sel_nm;
                wd_d        = wd_q + 1'b1;
                if ((bus_error_time > ERR_LIMIT) || (wd_q == HOLD_MAX - 1'b1)) begin
                    state_d  = ARB_ABORT;
                    bus_en_d = 1'b0;
                    abort_d  = gnt_q;
                end else if (!sel_req) begin
                    state_d  = ARB_RELEASE;
                    gnt_d    = '0;
                    bus_en_d = 1'b0;
                end
            end
            ARB_ABORT: begin
                if (!sel_req) begin
                    state_d = ARB_RELEASE;
                    gnt_d   = '0;
                    abort_d = '0;
                end
            end
            ARB_RELEASE: begin
                state_d  = ARB_IDLE;
                rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            abort_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            wd_q        <= '0;
            bus_en_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_wdata_q <= '0;
            bus_rdata_q <= '0;
            bus_nm_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            abort_q     <= abort_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            wd_q        <= wd_d;
            bus_en_q    <= bus_en_d;
            bus_wr_q    <= bus_wr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_rdata_q <= bus_rdata_d;
            bus_nm_q    <= bus_nm_d;
        end
    end

    always_comb begin
        done = '0;
        if ((state_q == ARB_OWNED) && bus_done) begin
            done = gnt_q;
        end
    end

    assign gnt       = gnt_q;
    assign abort     = abort_q;
    assign bus_en    = bus_en_q;
    assign bus_wr    = bus_wr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_rdata = bus_rdata_q;
    assign bus_nm    = bus_nm_q;
    assign busy      = (state_q != ARB_IDLE);

endmodule
